// File: rtl/line_tracker.sv
// Line-following tracker: synchronizes and debounces three IR sensor bits on a
// divided sample tick, then steers a motor stage through a small FSM.
module line_tracker #(
    parameter int unsigned SAMPLE_DIV   = 100000,
    parameter int unsigned FILT_LEN     = 4,
    parameter int unsigned LOST_TIMEOUT = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [2:0] sensor,
    output logic [2:0] mode,
    output logic [2:0] state,
    output logic       lost
);

    localparam int unsigned DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned RUN_W  = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam int unsigned LOST_W = $clog2(LOST_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FWD    = 3'd1,
        ST_LEFT   = 3'd2,
        ST_RIGHT  = 3'd3,
        ST_SEARCH = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    logic [2:0]       r_sync1;
    logic [2:0]       r_sync2;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic [RUN_W-1:0] r_run [3];
    logic [2:0]       r_filt;
    logic [LOST_W-1:0] r_lost_cnt;
    state_t           r_state;
    state_t           w_next_state;
    logic             r_last_dir;
    logic             w_next_last_dir;
    logic [2:0]       r_mode;
    logic [2:0]       w_next_mode;
    logic             r_lost;
    logic             w_next_lost;

    // Two-flop synchronizer for the asynchronous sensor inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= sensor;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-tick divider
    assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Per-bit debounce: a bit flips after FILT_LEN consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt <= 3'b000;
            for (int b = 0; b < 3; b++) begin
                r_run[b] <= '0;
            end
        end else if (w_tick) begin
            for (int b = 0; b < 3; b++) begin
                if (r_sync2[b] == r_filt[b]) begin
                    r_run[b] <= '0;
                end else if (r_run[b] == RUN_W'(FILT_LEN - 1)) begin
                    r_filt[b] <= ~r_filt[b];
                    r_run[b]  <= '0;
                end else begin
                    r_run[b] <= r_run[b] + RUN_W'(1);
                end
            end
        end
    end

    // Lost-tick counter: zero outside SEARCH, so every entry starts fresh
    always_ff @(posedge clk) begin
        if (rst || (r_state != ST_SEARCH)) begin
            r_lost_cnt <= '0;
        end else if (w_tick && (r_filt == 3'b000) &&
                     (r_lost_cnt != LOST_W'(LOST_TIMEOUT))) begin
            r_lost_cnt <= r_lost_cnt + LOST_W'(1);
        end
    end

    function automatic state_t decide(input logic [2:0] f, input state_t hold);
        case (f)
            3'b010, 3'b111: decide = ST_FWD;
            3'b100, 3'b110: decide = ST_LEFT;
            3'b001, 3'b011: decide = ST_RIGHT;
            3'b101:         decide = hold;
            default:        decide = ST_SEARCH;
        endcase
    endfunction

    // FSM state and registered output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last_dir <= 1'b0;
            r_mode     <= 3'b000;
            r_lost     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_last_dir <= w_next_last_dir;
            r_mode     <= w_next_mode;
            r_lost     <= w_next_lost;
        end
    end

    // Next-state and next-output decode; IDLE waits for a visible line before moving
    always_comb begin
        w_next_state    = r_state;
        w_next_last_dir = r_last_dir;
        w_next_mode     = 3'b000;
        w_next_lost     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_filt != 3'b000) w_next_state = decide(r_filt, ST_FWD);
            end
            ST_FWD, ST_LEFT, ST_RIGHT: begin
                w_next_state = decide(r_filt, r_state);
            end
            ST_SEARCH: begin
                if (r_lost_cnt == LOST_W'(LOST_TIMEOUT)) begin
                    w_next_state = ST_HALT;
                end else if (r_filt != 3'b000) begin
                    w_next_state = decide(r_filt, ST_FWD);
                end
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_IDLE;
        endcase

        if (!enable) w_next_state = ST_IDLE;

        if ((w_next_state == ST_LEFT) && (r_state != ST_LEFT)) w_next_last_dir = 1'b0;
        if ((w_next_state == ST_RIGHT) && (r_state != ST_RIGHT)) w_next_last_dir = 1'b1;

        case (w_next_state)
            ST_FWD:    w_next_mode = 3'b001;
            ST_LEFT:   w_next_mode = 3'b010;
            ST_RIGHT:  w_next_mode = 3'b011;
            ST_SEARCH: w_next_mode = {2'b11, w_next_last_dir};
            default:   w_next_mode = 3'b000;
        endcase

        w_next_lost = (w_next_state == ST_SEARCH) || (w_next_state == ST_HALT);
    end

    assign mode  = r_mode;
    assign state = r_state;
    assign lost  = r_lost;

endmodule

// File: tb/tb_line_tracker.sv
// Bench for line_tracker: directed scenarios plus randomized sensor/enable traffic,
// each cycle compared against a tick-counting reference model.
module tb_line_tracker;

    localparam int unsigned SDIV = 4;
    localparam int unsigned FLEN = 3;
    localparam int unsigned LTO  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] sensor;
    logic [2:0] mode;
    logic [2:0] state;
    logic       lost;

    int n_checks = 0;
    int n_pass   = 0;

    line_tracker #(
        .SAMPLE_DIV  (SDIV),
        .FILT_LEN    (FLEN),
        .LOST_TIMEOUT(LTO)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .enable(enable),
        .sensor(sensor),
        .mode  (mode),
        .state (state),
        .lost  (lost)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset, sensor history, debounce streaks, FSM state
    int         m_edges;
    logic [2:0] m_pipe[$];
    logic [2:0] m_f;
    int         m_streak[3];
    int         m_st;
    int         m_lt;
    bit         m_dir;
    int         m_nxt;
    logic [2:0] m_smp;
    bit         m_tk;

    function automatic int decide(input logic [2:0] f, input int hold_st);
        if (f == 3'b010 || f == 3'b111) return 1;
        if (f == 3'b100 || f == 3'b110) return 2;
        if (f == 3'b001 || f == 3'b011) return 3;
        if (f == 3'b101) return hold_st;
        return 4;
    endfunction

    function automatic logic [6:0] exp_outs();
        logic [2:0] md;
        case (m_st)
            1:       md = 3'b001;
            2:       md = 3'b010;
            3:       md = 3'b011;
            4:       md = m_dir ? 3'b111 : 3'b110;
            default: md = 3'b000;
        endcase
        return {md, 3'(m_st), (m_st == 4 || m_st == 5)};
    endfunction

    function automatic bit f_change_next();
        bit chg = 0;
        if (((m_edges + 1) % SDIV) == 0) begin
            for (int b = 0; b < 3; b++) begin
                if (m_pipe[0][b] != m_f[b] && m_streak[b] == FLEN - 1) chg = 1;
            end
        end
        return chg;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_edges = 0;
            m_pipe  = '{3'b000, 3'b000};
            m_f     = 3'b000;
            for (int b = 0; b < 3; b++) m_streak[b] = 0;
            m_st  = 0;
            m_lt  = 0;
            m_dir = 0;
        end else begin
            m_edges = m_edges + 1;
            m_tk    = (m_edges % SDIV) == 0;
            m_smp   = m_pipe.pop_front();
            m_pipe.push_back(sensor);
            if (!enable) m_nxt = 0;
            else begin
                case (m_st)
                    0:       m_nxt = (m_f == 3'b000) ? 0 : decide(m_f, 1);
                    1, 2, 3: m_nxt = decide(m_f, m_st);
                    4:       m_nxt = (m_lt >= LTO) ? 5 : ((m_f == 3'b000) ? 4 : decide(m_f, 1));
                    default: m_nxt = 5;
                endcase
            end
            if (m_st == 4 && m_tk && m_f == 3'b000 && m_lt < LTO) m_lt = m_lt + 1;
            if (m_nxt == 4 && m_st != 4) m_lt = 0;
            if (m_nxt == 2 && m_st != 2) m_dir = 0;
            if (m_nxt == 3 && m_st != 3) m_dir = 1;
            m_st = m_nxt;
            if (m_tk) begin
                for (int b = 0; b < 3; b++) begin
                    if (m_smp[b] == m_f[b]) m_streak[b] = 0;
                    else begin
                        m_streak[b] = m_streak[b] + 1;
                        if (m_streak[b] == FLEN) begin
                            m_f[b]      = ~m_f[b];
                            m_streak[b] = 0;
                        end
                    end
                end
            end
        end
    end

    task automatic restart(input logic [2:0] s);
        @(negedge clk);
        rst    = 1'b1;
        enable = 1'b1;
        sensor = s;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        enable = 1'b1;
        sensor = 3'($urandom_range(1, 7));
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mode, state, lost} !== 7'b0)
                $display("FAIL reset: got mode=%b state=%0d lost=%b, expected 000/0/0", mode, state, lost);
            else n_pass++;
        end
        rst = 1'b0;
    endtask

    task automatic test_acquire();
        logic [6:0] exp;
        restart(3'b010);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            exp = (n >= 13) ? {3'b001, 3'd1, 1'b0} : 7'b0;
            n_checks++;
            if ({mode, state, lost} !== exp)
                $display("FAIL acquire edge %0d: got %b, expected %b", n, {mode, state, lost}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        sensor = 3'b100;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (mode !== 3'b001) $display("FAIL glitch_hold: got mode=%b, expected 001", mode);
            else n_pass++;
        end
        sensor = 3'b010;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if (mode !== 3'b001) $display("FAIL glitch_reject: got mode=%b, expected 001", mode);
            else n_pass++;
        end
        sensor = 3'b100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mode, state, lost} !== exp_outs())
                $display("FAIL glitch_model: got %b, expected %b", {mode, state, lost}, exp_outs());
            else n_pass++;
        end
        n_checks++;
        if ({mode, state} !== {3'b010, 3'd2})
            $display("FAIL turn_left: got mode=%b state=%0d, expected 010/2", mode, state);
        else n_pass++;
        sensor = 3'b000;
        repeat (20) @(negedge clk);
        n_checks++;
        if ({mode, state, lost} !== {3'b110, 3'd4, 1'b1})
            $display("FAIL search_after_left: got %b, expected 1101001", {mode, state, lost});
        else n_pass++;
    endtask

    task automatic test_search_halt();
        restart(3'b001);
        repeat (16) @(negedge clk);
        sensor = 3'b000;
        repeat (16) @(negedge clk);
        n_checks++;
        if ({mode, state, lost} !== {3'b111, 3'd4, 1'b1})
            $display("FAIL search_right: got %b, expected 1111001", {mode, state, lost});
        else n_pass++;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mode, state, lost} !== exp_outs())
                $display("FAIL search_model: got %b, expected %b", {mode, state, lost}, exp_outs());
            else n_pass++;
        end
        n_checks++;
        if ({mode, state, lost} !== {3'b000, 3'd5, 1'b1})
            $display("FAIL halt: got %b, expected 0001011", {mode, state, lost});
        else n_pass++;
        sensor = 3'b010;
        repeat (20) @(negedge clk);
        n_checks++;
        if ({mode, state, lost} !== {3'b000, 3'd5, 1'b1})
            $display("FAIL halt_ignores_sensor: got %b, expected 0001011", {mode, state, lost});
        else n_pass++;
        enable = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mode, state, lost} !== 7'b0)
            $display("FAIL halt_exit: got %b, expected 0000000", {mode, state, lost});
        else n_pass++;
        enable = 1'b1;
    endtask

    task automatic test_search_recover();
        restart(3'b001);
        repeat (16) @(negedge clk);
        sensor = 3'b000;
        repeat (13) @(negedge clk);
        n_checks++;
        if (state !== 3'd4) $display("FAIL enter_search: got state=%0d, expected 4", state);
        else n_pass++;
        sensor = 3'b011;
        repeat (14) @(negedge clk);
        n_checks++;
        if ({mode, state, lost} !== {3'b011, 3'd3, 1'b0})
            $display("FAIL recover_right: got %b, expected 0110110", {mode, state, lost});
        else n_pass++;
        sensor = 3'b000;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mode, state, lost} !== exp_outs())
                $display("FAIL reentry_model: got %b, expected %b", {mode, state, lost}, exp_outs());
            else n_pass++;
        end
        n_checks++;
        if ({mode, state} !== {3'b111, 3'd4})
            $display("FAIL search_restart: got mode=%b state=%0d, expected 111/4", mode, state);
        else n_pass++;
        repeat (8) @(negedge clk);
        n_checks++;
        if (state !== 3'd5) $display("FAIL reentry_halt: got state=%0d, expected 5", state);
        else n_pass++;
    endtask

    task automatic test_hold_disable();
        bit hit = 0;
        restart(3'b100);
        repeat (16) @(negedge clk);
        sensor = 3'b101;
        repeat (16) @(negedge clk);
        n_checks++;
        if ({mode, state} !== {3'b010, 3'd2})
            $display("FAIL hold_101: got mode=%b state=%0d, expected 010/2", mode, state);
        else n_pass++;
        sensor = 3'b010;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            if (f_change_next()) begin
                enable = 1'b0;
                hit    = 1;
            end
        end
        n_checks++;
        if (!hit) $display("FAIL disable_sync: got no filter update, expected one within 40 cycles");
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if ({mode, state, lost} !== 7'b0)
                $display("FAIL disable_wins: got %b, expected 0000000", {mode, state, lost});
            else n_pass++;
        end
        enable = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({mode, state, lost} !== {3'b001, 3'd1, 1'b0})
            $display("FAIL reenable_fwd: got %b, expected 0010010", {mode, state, lost});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [6:0] exp;
        restart(3'b001);
        repeat (16) @(negedge clk);
        sensor = 3'b000;
        repeat (14) @(negedge clk);
        n_checks++;
        if (state !== 3'd4) $display("FAIL pre_reset_search: got state=%0d, expected 4", state);
        else n_pass++;
        rst    = 1'b1;
        sensor = 3'b010;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({mode, state, lost} !== 7'b0)
            $display("FAIL mid_reset: got %b, expected 0000000", {mode, state, lost});
        else n_pass++;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            exp = (n >= 13) ? {3'b001, 3'd1, 1'b0} : 7'b0;
            n_checks++;
            if ({mode, state, lost} !== exp)
                $display("FAIL reset_recovery edge %0d: got %b, expected %b", n, {mode, state, lost}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        int hold;
        restart(3'b000);
        for (int seg = 0; seg < 200; seg++) begin
            sensor = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(0, 7));
            enable = ($urandom_range(0, 15) != 0);
            rst    = ($urandom_range(0, 63) == 0);
            hold   = $urandom_range(1, 20);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                rst = 1'b0;
                n_checks++;
                if ({mode, state, lost} !== exp_outs())
                    $display("FAIL random seg %0d: got %b, expected %b", seg, {mode, state, lost}, exp_outs());
                else n_pass++;
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        sensor = 3'b000;
        test_reset();
        test_acquire();
        test_glitch();
        test_search_halt();
        test_search_recover();
        test_hold_disable();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/line_tracker.md
LINE_TRACKER -- requirements
Module: line_tracker

Interface
REQ-001 Parameter SAMPLE_DIV, default 100000, clk cycles per sensor sample tick (1 ms at 100 MHz); legal range >= 2.
REQ-002 Parameter FILT_LEN, default 4, consecutive identical samples needed to change a filtered sensor bit; legal range 1..15.
REQ-003 Parameter LOST_TIMEOUT, default 500, sample ticks spent in SEARCH before HALT; legal range 1..65535.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  run request; 0 forces IDLE.
REQ-007 sensor  input  3  raw IR tracker bits {left, center, right}, 1 = on line, asynchronous to clk.
REQ-008 mode  output  3  registered drive command to the motor stage: 000 stop, 001 forward, 010 left, 011 right, 110 reverse-left, 111 reverse-right; 1xx other than 110/111 never driven.
REQ-009 state  output  3  registered FSM state code: IDLE=0, FWD=1, LEFT=2, RIGHT=3, SEARCH=4, HALT=5.
REQ-010 lost  output  1  registered, 1 while state is SEARCH or HALT.

Function
REQ-011 sensor SHALL pass through a 2-flop synchronizer; only the synchronized value is sampled.
REQ-012 Divider counts 0..SAMPLE_DIV-1 and wraps; tick SHALL be 1 for exactly one cycle when the count equals SAMPLE_DIV-1.
REQ-013 Per bit, on tick: sample equal to filtered value clears that bit's run counter; a differing sample increments it, and on reaching FILT_LEN the filtered bit flips and the counter clears.
REQ-014 Filtered vector f updates on the tick edge; state, mode and lost SHALL update on the following edge (1-cycle decision latency).
REQ-015 Decision from f: 010 or 111 -> FWD; 100 or 110 -> LEFT; 001 or 011 -> RIGHT; 101 -> hold current state (IDLE/HALT excepted, see below); 000 -> SEARCH.
REQ-016 IDLE: mode 000; when enable=1, next state per REQ-015 decision, with 101 -> FWD.
REQ-017 FWD/LEFT/RIGHT: mode 001/010/011; next state per REQ-015 every cycle.
REQ-018 last_dir register: set 0 on entry to LEFT, 1 on entry to RIGHT, unchanged otherwise.
REQ-019 SEARCH: mode 110 if last_dir=0, else 111; lost-tick counter increments on each tick while f=000.
REQ-020 SEARCH exit: f nonzero -> state per REQ-015 (101 -> FWD), lost-tick counter cleared; counter reaching LOST_TIMEOUT -> HALT.
REQ-021 Lost-tick counter SHALL clear on every SEARCH entry.
REQ-022 HALT: mode 000, lost=1; ignores sensor; exits only to IDLE on enable=0.
REQ-023 enable=0 SHALL force IDLE on the next edge from any state, overriding all other transitions.
REQ-024 Simultaneous tick-driven f change and enable fall: enable rule wins.
REQ-025 Counters SHALL saturate, never wrap, and be sized to their parameter.

Reset
REQ-026 While rst=1 on an edge: state IDLE, mode 000, lost 0, f 000, synchronizer flops 0, divider 0, run counters 0, lost-tick counter 0, last_dir 0.
REQ-027 rst asserted mid-operation (any state) SHALL produce the REQ-026 values on that same edge; first tick after release occurs SAMPLE_DIV cycles later.

Verification (SAMPLE_DIV=4, FILT_LEN=3, LOST_TIMEOUT=5)
REQ-028 enable=1, sensor=010 held -> f=010 on the 3rd tick, mode=001 and state=1 one cycle later; no earlier change.
REQ-029 In FWD, sensor 100 for 2 ticks then 010 -> mode stays 001 (glitch rejected); sensor 100 for 3 ticks -> mode 010, last_dir=0.
REQ-030 From RIGHT, sensor 000 held -> SEARCH, mode 111, lost=1; after 5 further ticks -> HALT, mode 000; sensor 010 then has no effect until enable=0.
REQ-031 In SEARCH after 3 lost ticks, sensor 011 for 3 ticks -> RIGHT, mode 011, lost=0; re-entry to SEARCH restarts the 5-tick count.
REQ-032 In LEFT, sensor 101 filtered -> state stays LEFT; enable=0 same cycle as f update -> IDLE, mode 000.
REQ-033 rst pulsed for 1 cycle while in SEARCH -> next cycle all outputs 0, state IDLE; recovery requires 3 fresh ticks.
